ext_pipe: RTL
=============

Name: ext_pipe

Overview:
- Parametrised, pipelined successor to the fixed 16-to-32 zero extender.
- Performs immediate extension (zero, sign, LUI) and load-data extraction and extension (LB, LBU, LH, LHU, LW) in a single registered unit.
- Sits between the decode/immediate path and memory read-data on one side, and the writeback/ALU-operand mux on the other.
- Uses a valid/ready handshake with a 2-entry skid so that stalls do not create combinational ready paths.

Parameters:
- DATA_W, 32, output/word width; legal values are 32 or 64.
- TAG_W, 5, sideband tag (destination register number) carried alongside the data.
- OFF_W, $clog2(DATA_W/8), byte-offset width. This is derived and must not be overridden.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  unit can accept a beat.
- in_data  input  DATA_W  immediate (in low 16 bits) or memory read word.
- in_off  input  OFF_W  byte address offset for load modes.
- in_mode  input  3  operation select (see Behaviour).
- in_tag  input  TAG_W  passthrough tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DATA_W  extended result.
- out_tag  output  TAG_W  tag of the result.
- out_err  output  1  misalignment flag (ALIGN_CHECK_EN only).

Behaviour:
- Mode encoding:
  - 000 ZEXT16: zero-extend in_data[15:0].
  - 001 SEXT16: sign-extend in_data[15:0].
  - 010 LUI: in_data[15:0]<<16, zero-filled, with upper bits sign-extended from bit 31 when DATA_W=64.
  - 011 WORD: pass in_data unchanged.
  - 100 LB: sign-extend the byte at in_off.
  - 101 LBU: zero-extend the byte at in_off.
  - 110 LH: sign-extend the halfword at in_off[OFF_W-1:1].
  - 111 LHU: zero-extend the same halfword.
- Byte and halfword lanes are little-endian: byte k = in_data[8k+7:8k].
- Handshake:
  - A beat transfers when valid&&ready on the same edge.
  - in_valid must hold, with in_* stable, until accepted.
  - out_* must hold stable while out_valid&&!out_ready.
- Storage: output register (OR) plus skid register (SK); result is computed combinationally from in_* and captured at accept.
- Latency: 1 cycle from accept to out_valid when OR is empty or draining. Throughput is 1 beat/cycle while out_ready=1.
- in_ready = !SK_full. It is registered and does not depend combinationally on out_ready.
- Per-edge transfers:
  - Accept with OR empty, or OR draining (out_ready=1) and SK empty: result goes to OR.
  - Accept while OR full and not draining: result goes to SK; SK_full=1.
  - OR draining with SK full: SK moves to OR; SK_full=0. A simultaneous accept is impossible because in_ready=0.
  - Drain with no accept and SK empty: out_valid goes to 0.
- Order is strictly FIFO; no beat is dropped or duplicated.
- Reset, including mid-transfer:
  - out_valid=0, SK_full=0, in_ready=1 on the cycle after rst.
  - out_data=0, out_tag=0, out_err=0.
  - Any held beats are discarded.
  - in_ready is 0 during the rst cycle itself.
- in_off is ignored in modes 000–011 with checking disabled.

Optional Feature:
- Macro: EXT_PIPE_ALIGN_CHECK_EN.
- Defined:
  - out_err=1 for LH/LHU with in_off[0]=1, and for WORD with in_off!=0.
  - On error, out_data is forced to 0 while the tag and the handshake proceed normally.
  - err is registered and skidded alongside the data.
- Undefined:
  - out_err is tied 0.
  - LH/LHU ignore in_off[0].
  - WORD ignores in_off.

Decomposition:
- Package ext_pkg holds:
  - enum ext_mode_e with the 8 encodings above.
  - constants HALF_W=16, BYTE_W=8, LUI_SH=16.
- Sub-module ext_core: purely combinational mode/offset/extend datapath producing {err, data}.
- ext_pipe instantiates ext_core and owns the OR/SK registers and the handshake.

Test Plan:
- ZEXT16/SEXT16/LUI with in_data=32'h0000_8001, out_ready=1:
  - Expect 32'h0000_8001, 32'hFFFF_8001 and 32'h8001_0000 respectively.
  - Each result appears exactly 1 cycle after accept.
- LB/LBU with word 32'h80FF_7F01 at off=0..3:
  - LB expects 01, 7F, FFFFFFFF, FFFFFF80.
  - LBU expects 01, 7F, FF, 80 (zero-extended).
- LH/LHU with word 32'h8000_7FFF at off=2:
  - Expect FFFF8000 and 00008000.
  - With EXT_PIPE_ALIGN_CHECK_EN, off=1 gives out_err=1 and out_data=0.
- Back-pressure, streaming tags 1..6 with out_ready held 0 for 3 cycles:
  - in_ready drops after the 2nd beat.
  - On release, tags exit in order 1..6 with no loss or duplication.
  - out_* stay stable while stalled.
- Random valid/ready toggling for 1000 beats against a scoreboard model: all results match, in order.
- Assert rst while OR and SK are both full:
  - Next cycle out_valid=0 and in_ready=1.
  - A fresh beat (tag 9) emerges next with correct data.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared mode encodings and lane constants for the ext_pipe extender.
package ext_pkg;

   typedef enum logic [2:0] {
      EXT_ZEXT16 = 3'b000,
      EXT_SEXT16 = 3'b001,
      EXT_LUI    = 3'b010,
      EXT_WORD   = 3'b011,
      EXT_LB     = 3'b100,
      EXT_LBU    = 3'b101,
      EXT_LH     = 3'b110,
      EXT_LHU    = 3'b111
   } ext_mode_e;

   localparam int HALF_W = 16;
   localparam int BYTE_W = 8;
   localparam int LUI_SH = 16;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate/load-data extender producing {err, res}.
// Misalignment checking is enabled by EXT_PIPE_ALIGN_CHECK_EN.
module ext_core
   import ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] data,
   input  logic [OFF_W-1:0]  off,
   input  ext_mode_e         mode,
   output logic              err,
   output logic [DATA_W-1:0] res
);

   logic [DATA_W-1:0] b_sh;
   logic [DATA_W-1:0] h_sh;
   logic [BYTE_W-1:0] byte_v;
   logic [HALF_W-1:0] half_v;

   always_comb begin
      // Lanes are little-endian: shift the selected lane down to bit 0.
      b_sh   = data >> {off, 3'b000};
      h_sh   = data >> {off[OFF_W-1:1], 4'b0000};
      byte_v = b_sh[BYTE_W-1:0];
      half_v = h_sh[HALF_W-1:0];
      err    = 1'b0;
      res    = '0;
      case (mode)
         EXT_ZEXT16: res = {{(DATA_W-HALF_W){1'b0}}, data[HALF_W-1:0]};
         EXT_SEXT16: res = {{(DATA_W-HALF_W){data[HALF_W-1]}}, data[HALF_W-1:0]};
         EXT_LUI: begin
            res = data[HALF_W-1] ? '1 : '0;
            res[31:0] = {data[HALF_W-1:0], {LUI_SH{1'b0}}};
         end
         EXT_WORD:   res = data;
         EXT_LB:     res = {{(DATA_W-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
         EXT_LBU:    res = {{(DATA_W-BYTE_W){1'b0}}, byte_v};
         EXT_LH:     res = {{(DATA_W-HALF_W){half_v[HALF_W-1]}}, half_v};
         EXT_LHU:    res = {{(DATA_W-HALF_W){1'b0}}, half_v};
         default:    res = '0;
      endcase
`ifdef EXT_PIPE_ALIGN_CHECK_EN
      err = ((mode == EXT_LH || mode == EXT_LHU) && off[0]) ||
            ((mode == EXT_WORD) && (off != '0));
      if (err) res = '0;
`else
      err = 1'b0;
`endif
   end

endmodule

// File: rtl/ext_pipe.sv
// Registered extender with valid/ready handshake and a 2-entry (OR + skid) buffer.
// Optional misalignment flag via EXT_PIPE_ALIGN_CHECK_EN.
module ext_pipe
   import ext_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int TAG_W  = 5,
   localparam int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [OFF_W-1:0]  in_off,
   input  logic [2:0]        in_mode,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err
);

   logic              core_err;
   logic [DATA_W-1:0] core_res;

   logic              sk_full;
   logic [DATA_W-1:0] sk_data;
   logic [TAG_W-1:0]  sk_tag;
   logic              sk_err;

   logic accept;
   logic or_free;

   ext_core #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_core (
      .data (in_data),
      .off  (in_off),
      .mode (ext_mode_e'(in_mode)),
      .err  (core_err),
      .res  (core_res)
   );

   // Ready comes only from the skid flag, never from out_ready.
   assign in_ready = !sk_full && !rst;
   assign accept   = in_valid && in_ready;
   assign or_free  = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_err   <= 1'b0;
         sk_full   <= 1'b0;
         sk_data   <= '0;
         sk_tag    <= '0;
         sk_err    <= 1'b0;
      end else if (or_free) begin
         if (sk_full) begin
            out_valid <= 1'b1;
            out_data  <= sk_data;
            out_tag   <= sk_tag;
            out_err   <= sk_err;
            sk_full   <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= core_res;
            out_tag   <= in_tag;
            out_err   <= core_err;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         sk_full <= 1'b1;
         sk_data <= core_res;
         sk_tag  <= in_tag;
         sk_err  <= core_err;
      end
   end

endmodule
